branch_resolve_queue: RTL
=========================

Name: branch_resolve_queue

Overview:
- In-order tracking queue for predicted branches, between fetch/predict and the gshare predictor's update interface.
- Fetch allocates an entry per predicted branch; execute resolves entries out of order by tag.
- The queue retires strictly in order and drives the predictor update port (wr_en, orig_pc, is_taken, must_flush) plus a frontend redirect on mispredict.

Parameters:
- DEPTH, 8, number of in-flight branch entries; power of two, at least 2.
- TAG_W, $clog2(DEPTH), tag width (derived; do not override).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- alloc_valid  input  1  fetch requests an entry
- alloc_pc  input  32  branch PC
- alloc_pred_taken  input  1  predicted direction
- alloc_pred_target  input  32  predicted target (don't-care when not taken)
- alloc_ready  output  1  entry available this cycle
- alloc_tag  output  TAG_W  slot index granted (valid when alloc_valid & alloc_ready)
- res_valid  input  1  execute resolves a branch
- res_tag  input  TAG_W  slot being resolved
- res_taken  input  1  actual direction
- res_target  input  32  actual taken target
- ext_flush  input  1  pipeline kill (exception etc.); clears queue, no predictor update
- wr_en  output  1  predictor update strobe
- orig_pc  output  32  PC of retired branch
- is_taken  output  1  actual direction of retired branch
- must_flush  output  1  retired branch mispredicted
- redirect_pc  output  32  correct fetch PC (valid with must_flush)
- empty  output  1  no valid entries

Behaviour:
- Storage: circular buffer, head/tail pointers TAG_W bits with wrap; count register 0..DEPTH. Per slot: valid, resolved, pc, pred_taken, pred_target, act_taken, act_target.
- Reset (rst_n low at posedge): count=0, head=tail=0, all valid/resolved=0, wr_en=0, must_flush=0, orig_pc=0, is_taken=0, redirect_pc=0. Reset mid-operation discards all entries; no update is emitted.
- Allocate: alloc_ready = (count != DEPTH) & !must_flush & !ext_flush, based on registered count. A retire in the same cycle does not free space early. alloc_tag = tail. On an accepted allocation, the slot is written with valid=1, resolved=0, and tail increments mod DEPTH.
- Resolve: res_valid with valid[res_tag]=1 sets resolved and captures act_taken/act_target. Resolve to an invalid slot is silently ignored. Resolve is ignored in any cycle where must_flush or ext_flush is high.
- Retire: condition R = valid[head] & resolved[head]. On R, at the next edge:
  - wr_en=1, orig_pc=pc[head], is_taken=act_taken[head].
  - Mispredict M = (pred_taken != act_taken) | (act_taken & pred_target != act_target).
  - must_flush=M. redirect_pc = act_taken ? act_target : pc+4.
  - Head increments. Outputs are registered, so latency is 1 cycle from the cycle R holds; they are single-cycle pulses.
- Resolve and retire of the head in the same cycle: resolve is written that edge, R evaluates true the next cycle, wr_en follows one cycle later (2 cycles after res_valid).
- Max one retire per cycle. Back-to-back resolved entries retire on consecutive cycles.
- Mispredict retire (M=1): at the same edge that registers must_flush, all entries are invalidated, count=0, and head=tail=0. Younger entries are never updated.
- ext_flush: at the edge, all entries are invalidated, pointers and count zeroed, and wr_en/must_flush forced 0 for that edge. ext_flush wins over a simultaneous retire: that branch's update is dropped.
- Simultaneous alloc and retire (non-mispredict): count unchanged. Full (count=DEPTH): alloc_ready=0. Empty: empty=1, R false.
- Arithmetic: pc+4 is 32-bit modulo; pointers wrap modulo DEPTH.

Optional Feature:
- Macro BRQ_MISPRED_CNT_EN.
- Defined: adds outputs retire_cnt[31:0] and mispred_cnt[31:0].
  - retire_cnt increments on each wr_en pulse; mispred_cnt increments on each must_flush pulse.
  - Both wrap at 2^32, reset to 0 by rst_n, and are unaffected by ext_flush.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Alloc pc=0x100, pred_taken=1, target 0x200; resolve taken, target 0x200 -> exactly one wr_en 2 cycles after res_valid; orig_pc=0x100, is_taken=1, must_flush=0.
- Alloc tags 0,1,2 (pc 0x10/0x20/0x30, all pred not-taken); resolve order 2,0,1, all not-taken -> wr_en pulses in order 0x10, 0x20, 0x30 on consecutive cycles after tag1 resolves.
- Alloc 0x40 pred not-taken and 0x44; resolve 0x40 taken to 0x80 -> must_flush=1, redirect_pc=0x80, queue empty next cycle, 0x44 never updated; alloc_ready=0 during the must_flush cycle.
- Pred taken 0x50→0x60, actual taken 0x70 -> must_flush=1, redirect_pc=0x70, is_taken=1. Pred taken, actual not-taken at pc 0xFFFFFFFC -> redirect_pc=0x0.
- Fill 8 entries -> alloc_ready=0. Retire one with alloc_valid held -> alloc accepted the cycle after retire. Tail wraps to 0 and tags are reused correctly.
- ext_flush in the same cycle R holds -> no wr_en, empty=1 next cycle. Assert rst_n=0 with 5 entries in flight -> all outputs 0, empty=1, later resolves to old tags ignored.

Source files
------------

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order branch tracking queue feeding predictor updates and frontend redirects.
// Ports: clk/rst_n (sync, active-low); alloc_* allocate a slot at the tail and return alloc_tag;
// res_* resolve a slot by tag, out of order; ext_flush kills every entry; wr_en/orig_pc/is_taken/
// must_flush/redirect_pc are registered single-cycle retire outputs; empty flags no entries.
// Optional macro BRQ_MISPRED_CNT_EN adds retire_cnt/mispred_cnt event counters.
module branch_resolve_queue #(
    parameter int DEPTH = 8,
    localparam int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc_valid,
    input  logic [31:0]      alloc_pc,
    input  logic             alloc_pred_taken,
    input  logic [31:0]      alloc_pred_target,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             res_valid,
    input  logic [TAG_W-1:0] res_tag,
    input  logic             res_taken,
    input  logic [31:0]      res_target,
    input  logic             ext_flush,
    output logic             wr_en,
    output logic [31:0]      orig_pc,
    output logic             is_taken,
    output logic             must_flush,
    output logic [31:0]      redirect_pc,
    output logic             empty
`ifdef BRQ_MISPRED_CNT_EN
    ,
    output logic [31:0]      retire_cnt,
    output logic [31:0]      mispred_cnt
`endif
);
    logic [DEPTH-1:0] valid_q, valid_d, resolved_q, resolved_d, pred_taken_q, act_taken_q;
    logic [31:0]      pc_q [DEPTH];
    logic [31:0]      pred_target_q [DEPTH];
    logic [31:0]      act_target_q [DEPTH];
    logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;
    logic             wr_en_q, wr_en_d, must_flush_q, must_flush_d, is_taken_q, is_taken_d;
    logic [31:0]      orig_pc_q, orig_pc_d, redirect_pc_q, redirect_pc_d;
    logic             alloc_fire, res_fire, retire, mispred, update;

    // Space is judged on the registered count only, so a same-cycle retire never frees a slot early.
    assign alloc_ready = (count_q != (TAG_W+1)'(DEPTH)) & ~must_flush_q & ~ext_flush;
    assign alloc_tag   = tail_q;
    assign alloc_fire  = alloc_valid & alloc_ready;
    assign res_fire    = res_valid & valid_q[res_tag] & ~must_flush_q & ~ext_flush;
    assign retire      = valid_q[head_q] & resolved_q[head_q];
    assign mispred     = (pred_taken_q[head_q] != act_taken_q[head_q]) |
                         (act_taken_q[head_q] & (pred_target_q[head_q] != act_target_q[head_q]));
    // ext_flush drops a retire happening in the same cycle.
    assign update      = retire & ~ext_flush;
    assign empty       = count_q == '0;
    assign wr_en       = wr_en_q;
    assign must_flush  = must_flush_q;
    assign orig_pc     = orig_pc_q;
    assign is_taken    = is_taken_q;
    assign redirect_pc = redirect_pc_q;

    always_comb begin
        valid_d       = valid_q;
        resolved_d    = resolved_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(retire);
        wr_en_d       = update;
        must_flush_d  = update & mispred;
        orig_pc_d     = update ? pc_q[head_q] : orig_pc_q;
        is_taken_d    = update ? act_taken_q[head_q] : is_taken_q;
        redirect_pc_d = update ? (act_taken_q[head_q] ? act_target_q[head_q] : pc_q[head_q] + 32'd4)
                               : redirect_pc_q;
        if (alloc_fire) begin
            valid_d[tail_q]    = 1'b1;
            resolved_d[tail_q] = 1'b0;
            tail_d             = tail_q + TAG_W'(1);
        end
        if (res_fire)
            resolved_d[res_tag] = 1'b1;
        // Retire clears last so a re-resolve of the head cannot keep it alive.
        if (retire) begin
            valid_d[head_q]    = 1'b0;
            resolved_d[head_q] = 1'b0;
            head_d             = head_q + TAG_W'(1);
        end
        // A mispredict or external kill discards every younger entry, including one allocated now.
        if (ext_flush | (retire & mispred)) begin
            valid_d    = '0;
            resolved_d = '0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q       <= '0;
            resolved_q    <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            wr_en_q       <= 1'b0;
            must_flush_q  <= 1'b0;
            orig_pc_q     <= '0;
            is_taken_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            valid_q       <= valid_d;
            resolved_q    <= resolved_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            wr_en_q       <= wr_en_d;
            must_flush_q  <= must_flush_d;
            orig_pc_q     <= orig_pc_d;
            is_taken_q    <= is_taken_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    // Payload storage needs no reset: it is only read behind valid/resolved.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            pc_q[tail_q]          <= alloc_pc;
            pred_taken_q[tail_q]  <= alloc_pred_taken;
            pred_target_q[tail_q] <= alloc_pred_target;
        end
        if (res_fire) begin
            act_taken_q[res_tag]  <= res_taken;
            act_target_q[res_tag] <= res_target;
        end
    end

`ifdef BRQ_MISPRED_CNT_EN
    logic [31:0] retire_cnt_q, mispred_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retire_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            retire_cnt_q  <= retire_cnt_q + 32'(wr_en_d);
            mispred_cnt_q <= mispred_cnt_q + 32'(must_flush_d);
        end
    end

    assign retire_cnt  = retire_cnt_q;
    assign mispred_cnt = mispred_cnt_q;
`endif
endmodule
